// File: rtl/exc_ctrl_n_if.sv
// Pipeline <-> exception controller bus.
// Inputs to the controller: irq, sync_exc, wb_valid, pc_wb, delay_slot, eret, c0_we/c0_sel/c0_wd.
// Outputs from the controller: c0_rd, flush, e_enter, vector, exl, ipend.
// master = pipeline/core side, slave = exception controller.
interface exc_ctrl_n_if #(
    parameter int unsigned N_IRQ = 6,
    parameter int unsigned W     = 32
);
    logic [N_IRQ-1:0] irq;
    logic [6:0]       sync_exc;
    logic             wb_valid;
    logic [W-1:0]     pc_wb;
    logic             delay_slot;
    logic             eret;
    logic             c0_we;
    logic [2:0]       c0_sel;
    logic [31:0]      c0_wd;
    logic [31:0]      c0_rd;
    logic             flush;
    logic             e_enter;
    logic [W-1:0]     vector;
    logic             exl;
    logic [N_IRQ-1:0] ipend;

    modport master (
        output irq, sync_exc, wb_valid, pc_wb, delay_slot, eret, c0_we, c0_sel, c0_wd,
        input  c0_rd, flush, e_enter, vector, exl, ipend
    );

    modport slave (
        input  irq, sync_exc, wb_valid, pc_wb, delay_slot, eret, c0_we, c0_sel, c0_wd,
        output c0_rd, flush, e_enter, vector, exl, ipend
    );
endinterface

// File: rtl/exc_ctrl_n.sv
// Exception / interrupt controller: STATUS, CAUSE, EPC coprocessor-0 state,
// synchronised external interrupts (per-line edge/level), flush and redirect vector.
// Ports: clk, reset_n (async active-low), bus (exc_ctrl_n_if.slave).
// Optional feature macro: EXC_TIMER_EN builds the COUNT/COMPARE timer and TI.
module exc_ctrl_n #(
    parameter int unsigned      N_IRQ     = 6,
    parameter int unsigned      W         = 32,
    parameter logic [N_IRQ-1:0] EDGE_MASK = '0,
    parameter logic [W-1:0]     RST_VEC   = W'(32'h0000_0000),
    parameter logic [W-1:0]     EXC_VEC   = W'(32'h0000_0100)
) (
    input  logic        clk,
    input  logic        reset_n,
    exc_ctrl_n_if.slave bus
);
    localparam int unsigned CODE_W = 5;
    localparam int unsigned IM_LSB = 8;

    localparam logic [2:0] SEL_STATUS  = 3'd0;
    localparam logic [2:0] SEL_CAUSE   = 3'd1;
    localparam logic [2:0] SEL_EPC     = 3'd2;
    localparam logic [2:0] SEL_COUNT   = 3'd3;
    localparam logic [2:0] SEL_COMPARE = 3'd4;

    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    state_t              state, state_nxt;
    logic                boot;
    logic [N_IRQ-1:0]    irq_s1, irq_s2, irq_s3;
    logic [N_IRQ-1:0]    ip_edge, ip, im, w1c;
    logic                ie, exl, imt, bd;
    logic [CODE_W-1:0]   code, exc_code;
    logic [W-1:0]        epc;
    logic                ti;
    logic [31:0]         count, compare;
    logic                int_req, e_enter, c0_wr;
    logic [31:0]         rd;
    logic [W-1:0]        vec;

    // Boot sequencer: one redirect-to-reset-vector cycle after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_BOOT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        boot      = 1'b0;
        case (state)
            ST_BOOT: begin
                boot      = 1'b1;
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Two-flop synchroniser plus a third stage for rising-edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
            irq_s3 <= '0;
        end else begin
            irq_s1 <= bus.irq;
            irq_s2 <= irq_s1;
            irq_s3 <= irq_s2;
        end
    end

    assign c0_wr = bus.c0_we & ~e_enter;
    assign w1c   = (c0_wr && bus.c0_sel == SEL_CAUSE) ? bus.c0_wd[IM_LSB +: N_IRQ] : '0;

    // Edge pending latches: set has priority over software W1C
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ip_edge <= '0;
        else          ip_edge <= (ip_edge & ~w1c) | (irq_s2 & ~irq_s3 & EDGE_MASK);
    end

    assign ip = (ip_edge & EDGE_MASK) | (irq_s2 & ~EDGE_MASK);

`ifdef EXC_TIMER_EN
    // Free-running timer; a COMPARE write clears TI even on a coincident match
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            count <= (c0_wr && bus.c0_sel == SEL_COUNT) ? bus.c0_wd : count + 32'd1;
            if (c0_wr && bus.c0_sel == SEL_COMPARE) begin
                compare <= bus.c0_wd;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end
    assign int_req = bus.wb_valid & ie & ~exl & ((|(ip & im)) | (ti & imt));
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
    assign int_req = bus.wb_valid & ie & ~exl & (|(ip & im));
`endif

    // Fixed-priority cause encoder: IBE, RI, CpU, BREAK, SYSCALL, OV, DBE, interrupt
    always_comb begin
        exc_code = CODE_W'(0);
        if      (bus.sync_exc[6]) exc_code = CODE_W'(6);
        else if (bus.sync_exc[5]) exc_code = CODE_W'(10);
        else if (bus.sync_exc[4]) exc_code = CODE_W'(11);
        else if (bus.sync_exc[3]) exc_code = CODE_W'(9);
        else if (bus.sync_exc[2]) exc_code = CODE_W'(8);
        else if (bus.sync_exc[1]) exc_code = CODE_W'(12);
        else if (bus.sync_exc[0]) exc_code = CODE_W'(7);
    end

    assign e_enter = ~boot & ((|bus.sync_exc) | int_req);

    // CP0 STATUS/CAUSE/EPC; entry wins over ERET and drops a coincident MTC0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie   <= 1'b0;
            exl  <= 1'b0;
            im   <= '0;
            imt  <= 1'b0;
            bd   <= 1'b0;
            code <= '0;
            epc  <= '0;
        end else if (e_enter) begin
            code <= exc_code;
            exl  <= 1'b1;
            if (!exl) begin
                epc <= bus.delay_slot ? bus.pc_wb - W'(4) : bus.pc_wb;
                bd  <= bus.delay_slot;
            end
        end else begin
            if (bus.eret) exl <= 1'b0;
            if (c0_wr && bus.c0_sel == SEL_STATUS) begin
                ie  <= bus.c0_wd[0];
                exl <= bus.c0_wd[1];
                im  <= bus.c0_wd[IM_LSB +: N_IRQ];
                imt <= bus.c0_wd[15];
            end
            if (c0_wr && bus.c0_sel == SEL_EPC) epc <= W'(bus.c0_wd);
        end
    end

    // CP0 read mux; unlisted bits read zero
    always_comb begin
        rd = '0;
        case (bus.c0_sel)
            SEL_STATUS: begin
                rd[0]                = ie;
                rd[1]                = exl;
                rd[IM_LSB +: N_IRQ]  = im;
                rd[15]               = imt;
            end
            SEL_CAUSE: begin
                rd[31]               = bd;
                rd[30]               = ti;
                rd[IM_LSB +: N_IRQ]  = ip;
                rd[6:2]              = code;
            end
            SEL_EPC:     rd = 32'(epc);
            SEL_COUNT:   rd = count;
            SEL_COMPARE: rd = compare;
            default:     rd = '0;
        endcase
    end

    // Redirect target: reset vector while booting, else entry, else ERET return
    always_comb begin
        vec = EXC_VEC;
        if (boot)          vec = RST_VEC;
        else if (e_enter)  vec = EXC_VEC;
        else if (bus.eret) vec = epc;
    end

    assign bus.c0_rd   = rd;
    assign bus.flush   = e_enter | bus.eret | boot;
    assign bus.e_enter = e_enter;
    assign bus.vector  = vec;
    assign bus.exl     = exl;
    assign bus.ipend   = ip;
endmodule

// File: tb/tb_exc_ctrl_n.sv
// Directed self-checking bench for exc_ctrl_n (edge mode on IRQ line 2).
module tb_exc_ctrl_n;
    localparam int unsigned N_IRQ = 6;
    localparam int unsigned W     = 32;
    localparam logic [31:0] TI_M  = 32'h4000_0000;

    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_checks;

    exc_ctrl_n_if #(.N_IRQ(N_IRQ), .W(W)) bus ();

    exc_ctrl_n #(
        .N_IRQ    (N_IRQ),
        .W        (W),
        .EDGE_MASK(6'b000100),
        .RST_VEC  (32'h0000_0000),
        .EXC_VEC  (32'h0000_0100)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_c0(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        bus.c0_sel = sel;
        #1;
        check(tag, bus.c0_rd, exp);
    endtask

    // CAUSE compare ignoring TI (timer may match COUNT==COMPARE==0 after reset)
    task automatic chk_cause(input string tag, input logic [31:0] exp);
        bus.c0_sel = 3'd1;
        #1;
        check(tag, bus.c0_rd & ~TI_M, exp);
    endtask

    task automatic c0_write(input logic [2:0] sel, input logic [31:0] wd);
        bus.c0_we  = 1'b1;
        bus.c0_sel = sel;
        bus.c0_wd  = wd;
        tick();
        bus.c0_we  = 1'b0;
    endtask

    task automatic do_eret(input logic [31:0] exp_vec);
        bus.eret = 1'b1;
        #1;
        check("eret_flush", 32'(bus.flush), 32'd1);
        check("eret_vec", bus.vector, exp_vec);
        tick();
        bus.eret = 1'b0;
        #1;
        check("eret_exl", 32'(bus.exl), 32'd0);
    endtask

    initial begin
        n_pass     = 0;
        n_checks   = 0;
        reset_n    = 1'b0;
        bus.irq        = '0;
        bus.sync_exc   = '0;
        bus.wb_valid   = 1'b0;
        bus.pc_wb      = '0;
        bus.delay_slot = 1'b0;
        bus.eret       = 1'b0;
        bus.c0_we      = 1'b0;
        bus.c0_sel     = '0;
        bus.c0_wd      = '0;

        // Reset and boot cycle
        tick();
        tick();
        check("rst_flush", 32'(bus.flush), 32'd1);
        check("rst_vec", bus.vector, 32'h0);
        check("rst_exl", 32'(bus.exl), 32'd0);
        check("rst_ipend", 32'(bus.ipend), 32'd0);
        reset_n = 1'b1;
        #1;
        check("boot_flush", 32'(bus.flush), 32'd1);
        check("boot_vec", bus.vector, 32'h0);
        bus.sync_exc = 7'b0100000;
        #1;
        check("boot_no_enter", 32'(bus.e_enter), 32'd0);
        bus.sync_exc = '0;
        chk_c0("boot_status", 3'd0, 32'h0);
        chk_c0("boot_cause", 3'd1, 32'h0);
        chk_c0("boot_epc", 3'd2, 32'h0);
        chk_c0("boot_count", 3'd3, 32'h0);
        chk_c0("boot_compare", 3'd4, 32'h0);
        tick();
        check("post_boot_flush", 32'(bus.flush), 32'd0);

        // RI+OV in a delay slot
        bus.sync_exc   = 7'b0100010;
        bus.wb_valid   = 1'b1;
        bus.pc_wb      = 32'h400;
        bus.delay_slot = 1'b1;
        #1;
        check("riov_flush", 32'(bus.flush), 32'd1);
        check("riov_enter", 32'(bus.e_enter), 32'd1);
        check("riov_vec", bus.vector, 32'h100);
        tick();
        bus.sync_exc   = '0;
        bus.wb_valid   = 1'b0;
        bus.delay_slot = 1'b0;
        chk_cause("riov_cause", 32'h8000_0028);
        chk_c0("riov_epc", 3'd2, 32'h3FC);
        chk_c0("riov_status", 3'd0, 32'h2);

        // Nested IBE: EPC/BD held, code updated
        bus.sync_exc = 7'b1000000;
        bus.pc_wb    = 32'h800;
        #1;
        check("ibe_vec", bus.vector, 32'h100);
        check("ibe_enter", 32'(bus.e_enter), 32'd1);
        tick();
        bus.sync_exc = '0;
        chk_cause("ibe_cause", 32'h8000_0018);
        chk_c0("ibe_epc", 3'd2, 32'h3FC);
        do_eret(32'h3FC);

        // MTC0 STATUS coincident with SYSCALL is dropped
        bus.sync_exc = 7'b0000100;
        bus.pc_wb    = 32'h500;
        bus.c0_we    = 1'b1;
        bus.c0_sel   = 3'd0;
        bus.c0_wd    = 32'h1;
        tick();
        bus.sync_exc = '0;
        bus.c0_we    = 1'b0;
        chk_c0("sys_status", 3'd0, 32'h2);
        chk_cause("sys_cause", 32'h0000_0020);
        chk_c0("sys_epc", 3'd2, 32'h500);
        do_eret(32'h500);

        // EPC software write
        c0_write(3'd2, 32'h1234);
        chk_c0("epc_wr", 3'd2, 32'h1234);

        // Edge IRQ on line 2: three edges to pending, then interrupt entry
        c0_write(3'd0, 32'h401);
        chk_c0("im_status", 3'd0, 32'h401);
        bus.irq[2] = 1'b1;
        tick();
        bus.irq[2] = 1'b0;
        check("edge_e1", 32'(bus.ipend), 32'h0);
        tick();
        check("edge_e2", 32'(bus.ipend), 32'h0);
        tick();
        check("edge_e3", 32'(bus.ipend), 32'h4);
        check("edge_no_wb", 32'(bus.e_enter), 32'd0);
        bus.wb_valid = 1'b1;
        bus.pc_wb    = 32'h600;
        #1;
        check("int_enter", 32'(bus.e_enter), 32'd1);
        check("int_vec", bus.vector, 32'h100);
        tick();
        bus.wb_valid = 1'b0;
        chk_cause("int_cause", 32'h0000_0400);
        chk_c0("int_epc", 3'd2, 32'h600);
        check("int_exl", 32'(bus.exl), 32'd1);
        check("edge_hold", 32'(bus.ipend), 32'h4);
        c0_write(3'd1, 32'h400);
        check("w1c_ipend", 32'(bus.ipend), 32'h0);
        do_eret(32'h600);

        // Level IRQ on line 0 (masked): two edges to pending, follows the line
        bus.irq[0] = 1'b1;
        tick();
        check("lvl_e1", 32'(bus.ipend), 32'h0);
        tick();
        check("lvl_e2", 32'(bus.ipend), 32'h1);
        bus.wb_valid = 1'b1;
        #1;
        check("lvl_masked", 32'(bus.e_enter), 32'd0);
        bus.wb_valid = 1'b0;
        bus.irq[0]   = 1'b0;
        tick();
        tick();
        check("lvl_drop", 32'(bus.ipend), 32'h0);

        // Timer
        c0_write(3'd3, 32'h0);
        c0_write(3'd4, 32'h5);
        c0_write(3'd0, 32'h8001);
        chk_c0("tmr_status", 3'd0, 32'h8001);
`ifdef EXC_TIMER_EN
        chk_c0("tmr_count2", 3'd3, 32'h2);
        tick();
        tick();
        tick();
        chk_c0("tmr_count5", 3'd3, 32'h5);
        chk_c0("tmr_ti0", 3'd1, 32'h0);
        tick();
        chk_c0("tmr_ti1", 3'd1, 32'h4000_0000);
        bus.wb_valid = 1'b1;
        bus.pc_wb    = 32'h700;
        #1;
        check("tmr_enter", 32'(bus.e_enter), 32'd1);
        check("tmr_vec", bus.vector, 32'h100);
        tick();
        bus.wb_valid = 1'b0;
        check("tmr_exl", 32'(bus.exl), 32'd1);
        chk_c0("tmr_epc", 3'd2, 32'h700);
        c0_write(3'd4, 32'h9);
        chk_c0("tmr_ti_clr", 3'd1, 32'h0);
        chk_c0("tmr_compare", 3'd4, 32'h9);
        do_eret(32'h700);
`else
        tick();
        tick();
        tick();
        tick();
        bus.wb_valid = 1'b1;
        bus.pc_wb    = 32'h700;
        #1;
        check("notmr_no_int", 32'(bus.e_enter), 32'd0);
        bus.wb_valid = 1'b0;
        chk_c0("notmr_count", 3'd3, 32'h0);
        chk_c0("notmr_compare", 3'd4, 32'h0);
        chk_c0("notmr_cause", 3'd1, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
